// File: rtl/hbt_pkg.sv
// rtl/hbt_pkg.sv - shared types and index fold for the history bit table controller
package hbt_pkg;

  typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} hbt_state_e;

  typedef struct packed {
    logic [15:0] pc;
    logic        taken;
  } upd_entry_t;

  // Low PC bits select the entry; indices past the table end wrap back once.
  function automatic logic [15:0] idx_fold(input logic [15:0] pc, input int unsigned idx_w,
                                           input int unsigned size);
    logic [15:0] mask;
    logic [15:0] i;
    mask = (16'd1 << idx_w) - 16'd1;
    i    = pc & mask;
    if (i >= 16'(size)) i = i - 16'(size);
    return i;
  endfunction

endpackage

// File: rtl/hbt_upd_fifo.sv
// rtl/hbt_upd_fifo.sv - 2-entry update queue with per-entry read-out for forwarding
module hbt_upd_fifo import hbt_pkg::*; (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush_i,
  input  logic       push_i,
  input  upd_entry_t push_data_i,
  input  logic       pop_i,
  output logic [1:0] count_o,
  output upd_entry_t ent0_o,
  output upd_entry_t ent1_o
);

  upd_entry_t slot_q [2];
  upd_entry_t slot_d [2];
  logic [1:0] count_q;
  logic [1:0] count_d;
  logic [1:0] after_pop;

  // Slot 0 is always the oldest entry; a pop shifts slot 1 down.
  always_comb begin
    slot_d[0] = slot_q[0];
    slot_d[1] = slot_q[1];
    after_pop = count_q;
    if (pop_i && count_q != 2'd0) begin
      slot_d[0] = slot_q[1];
      after_pop = count_q - 2'd1;
    end
    count_d = after_pop;
    if (push_i && after_pop != 2'd2) begin
      slot_d[after_pop[0]] = push_data_i;
      count_d              = after_pop + 2'd1;
    end
    if (flush_i) count_d = 2'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q   <= 2'd0;
      slot_q[0] <= '0;
      slot_q[1] <= '0;
    end else begin
      count_q   <= count_d;
      slot_q[0] <= slot_d[0];
      slot_q[1] <= slot_d[1];
    end
  end

  assign count_o = count_q;
  assign ent0_o  = slot_q[0];
  assign ent1_o  = slot_q[1];

endmodule

// File: rtl/hbt_ctrl.sv
// rtl/hbt_ctrl.sv - single-port HBT arbiter: lookups, queued updates with forwarding, clear walk
module hbt_ctrl import hbt_pkg::*; #(
  parameter int SIZE       = 200,
  parameter int IDX_W      = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inv,
  input  logic        lk_req,
  input  logic [15:0] lk_pc,
  output logic        lk_ready,
  output logic        lk_vld,
  output logic        lk_hit,
  output logic        lk_taken,
  input  logic        up_req,
  input  logic [15:0] up_pc,
  input  logic        up_taken,
  output logic        up_ready,
  output logic [15:0] tbl_addr,
  output logic [15:0] tbl_din,
  output logic        tbl_w,
  output logic        tbl_hbin,
  input  logic [15:0] tbl_dout,
  input  logic        tbl_hbout,
  output logic        busy
);

  localparam int ST_W = $clog2(STARVE_MAX + 1);

  hbt_state_e      state_q;
  logic [15:0]     clr_ptr_q;
  logic [ST_W-1:0] starve_q;
  logic            lk_vld_q, lk_hit_q, lk_taken_q;

  logic [1:0]  q_count;
  upd_entry_t  q_head, q_ent1;
  logic        run, q_empty, q_full, drain, lk_acc, push;
  logic [15:0] lk_idx;
  logic        fwd_hit, fwd_taken;

  hbt_upd_fifo u_fifo (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (inv),
    .push_i      (push),
    .push_data_i ('{pc: up_pc, taken: up_taken}),
    .pop_i       (drain),
    .count_o     (q_count),
    .ent0_o      (q_head),
    .ent1_o      (q_ent1)
  );

  assign run      = (state_q == ST_RUN);
  assign q_empty  = (q_count == 2'd0);
  assign q_full   = (q_count == 2'd2);
  // A full queue or an exhausted starve budget forces the head out ahead of a lookup.
  assign drain    = run & ~q_empty & (~lk_req | q_full | (starve_q == ST_W'(STARVE_MAX)));
  assign lk_ready = run & ~drain;
  assign lk_acc   = lk_req & lk_ready;
  assign up_ready = run & (~q_full | drain);
  assign push     = up_req & up_ready;
  assign lk_idx   = idx_fold(lk_pc, IDX_W, SIZE);

  // Newest queued entry for the same index overrides the table read.
  always_comb begin
    fwd_hit   = (tbl_dout == lk_pc);
    fwd_taken = fwd_hit & tbl_hbout;
    if (q_full && idx_fold(q_ent1.pc, IDX_W, SIZE) == lk_idx) begin
      fwd_hit   = (q_ent1.pc == lk_pc);
      fwd_taken = fwd_hit & q_ent1.taken;
    end else if (!q_empty && idx_fold(q_head.pc, IDX_W, SIZE) == lk_idx) begin
      fwd_hit   = (q_head.pc == lk_pc);
      fwd_taken = fwd_hit & q_head.taken;
    end
  end

  always_comb begin
    tbl_addr = lk_idx;
    tbl_din  = 16'd0;
    tbl_hbin = 1'b0;
    tbl_w    = 1'b0;
    if (!run) begin
      tbl_addr = clr_ptr_q;
      tbl_w    = 1'b1;
    end else if (drain) begin
      tbl_addr = idx_fold(q_head.pc, IDX_W, SIZE);
      tbl_din  = q_head.pc;
      tbl_hbin = q_head.taken;
      tbl_w    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_CLEAR;
      clr_ptr_q  <= 16'd0;
      starve_q   <= '0;
      lk_vld_q   <= 1'b0;
      lk_hit_q   <= 1'b0;
      lk_taken_q <= 1'b0;
    end else begin
      lk_vld_q   <= lk_acc;
      lk_hit_q   <= lk_acc & fwd_hit;
      lk_taken_q <= lk_acc & fwd_taken;
      if (inv) begin
        state_q   <= ST_CLEAR;
        clr_ptr_q <= 16'd0;
        starve_q  <= '0;
      end else begin
        case (state_q)
          ST_CLEAR: begin
            clr_ptr_q <= clr_ptr_q + 16'd1;
            if (clr_ptr_q == 16'(SIZE - 1)) begin
              state_q   <= ST_RUN;
              clr_ptr_q <= 16'd0;
            end
          end
          ST_RUN: begin
            if (drain) starve_q <= '0;
            else if (lk_acc && !q_empty) starve_q <= starve_q + ST_W'(1);
          end
          default: state_q <= ST_CLEAR;
        endcase
      end
    end
  end

  assign lk_vld   = lk_vld_q;
  assign lk_hit   = lk_hit_q;
  assign lk_taken = lk_taken_q;
  assign busy     = ~run;

endmodule

// File: tb/tb_hbt_ctrl.sv
// tb/tb_hbt_ctrl.sv - self-checking bench for hbt_ctrl with table memory and reference model
module tb_hbt_ctrl;

  localparam int SIZE = 200;

  logic        clk = 1'b0;
  logic        reset, inv, lk_req, up_req, up_taken;
  logic [15:0] lk_pc, up_pc;
  logic        lk_ready, lk_vld, lk_hit, lk_taken, up_ready;
  logic [15:0] tbl_addr, tbl_din, tbl_dout;
  logic        tbl_w, tbl_hbin, tbl_hbout, busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] mem_pc [SIZE];
  logic        mem_hb [SIZE];
  logic [15:0] mdl_pc [SIZE];
  logic        mdl_hb [SIZE];
  logic        mon_en = 1'b0;
  logic        exp_vld = 1'b0, exp_hit = 1'b0, exp_taken = 1'b0;

  hbt_ctrl #(.SIZE(SIZE), .IDX_W(8), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset), .inv(inv),
    .lk_req(lk_req), .lk_pc(lk_pc), .lk_ready(lk_ready),
    .lk_vld(lk_vld), .lk_hit(lk_hit), .lk_taken(lk_taken),
    .up_req(up_req), .up_pc(up_pc), .up_taken(up_taken), .up_ready(up_ready),
    .tbl_addr(tbl_addr), .tbl_din(tbl_din), .tbl_w(tbl_w), .tbl_hbin(tbl_hbin),
    .tbl_dout(tbl_dout), .tbl_hbout(tbl_hbout), .busy(busy)
  );

  always #5 clk = ~clk;

  // External single-port table: combinational read, write on the falling edge.
  assign tbl_dout  = (tbl_addr < 16'(SIZE)) ? mem_pc[tbl_addr] : 16'h0;
  assign tbl_hbout = (tbl_addr < 16'(SIZE)) ? mem_hb[tbl_addr] : 1'b0;
  always @(negedge clk) begin
    if (tbl_w && tbl_addr < 16'(SIZE)) begin
      mem_pc[tbl_addr] <= tbl_din;
      mem_hb[tbl_addr] <= tbl_hbin;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int mdl_idx(input logic [15:0] pc);
    int i;
    i = pc % 256;
    if (i >= SIZE) i = i - SIZE;
    return i;
  endfunction

  function automatic logic [15:0] rnd_pc();
    logic [7:0] lo;
    case ($urandom % 6)
      0: lo = 8'h08;
      1: lo = 8'h12;
      2: lo = 8'hD0;
      3: lo = 8'h30;
      4: lo = 8'h00;
      default: lo = 8'($urandom);
    endcase
    return {8'($urandom_range(0, 2)), lo};
  endfunction

  task automatic model_wipe();
    for (int i = 0; i < SIZE; i++) begin
      mdl_pc[i] = 16'h0;
      mdl_hb[i] = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Architectural view: a lookup sees every update accepted in an earlier cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      check("lk_vld", lk_vld, exp_vld);
      if (exp_vld) begin
        check("lk_hit", lk_hit, exp_hit);
        check("lk_taken", lk_taken, exp_taken);
      end
      exp_vld = lk_req && lk_ready;
      if (exp_vld) begin
        exp_hit   = (mdl_pc[mdl_idx(lk_pc)] == lk_pc);
        exp_taken = exp_hit && mdl_hb[mdl_idx(lk_pc)];
      end
      if (inv) model_wipe();
      else if (up_req && up_ready) begin
        mdl_pc[mdl_idx(up_pc)] = up_pc;
        mdl_hb[mdl_idx(up_pc)] = up_taken;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  logic [15:0] pcs [3];
  int          grants;
  logic        found, got, forced;

  initial begin
    for (int i = 0; i < SIZE; i++) begin
      mem_pc[i] = 16'hBEEF;
      mem_hb[i] = 1'b1;
    end
    model_wipe();
    reset = 1'b1; inv = 1'b0; lk_req = 1'b0; lk_pc = 16'h0;
    up_req = 1'b0; up_pc = 16'h0; up_taken = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 1);
    check("rst_lk_vld", lk_vld, 0);
    check("rst_lk_hit", lk_hit, 0);
    check("rst_lk_taken", lk_taken, 0);
    check("rst_lk_ready", lk_ready, 0);
    check("rst_up_ready", up_ready, 0);
    check("rst_addr", tbl_addr, 0);
    step();
    reset = 1'b0;

    for (int k = 0; k < SIZE; k++) begin
      @(negedge clk);
      check("clr_busy", busy, 1);
      check("clr_w", tbl_w, 1);
      check("clr_addr", tbl_addr, k);
      check("clr_din", tbl_din, 0);
      step();
    end
    @(negedge clk);
    check("run_busy", busy, 0);
    check("run_lk_ready", lk_ready, 1);
    mon_en = 1'b1;
    step();

    // Plain update drains on the next cycle when no lookup competes.
    up_req = 1'b1; up_pc = 16'h0012; up_taken = 1'b1;
    step();
    up_req = 1'b0;
    @(negedge clk);
    check("drain_w", tbl_w, 1);
    check("drain_addr", tbl_addr, 16'h0012);
    check("drain_din", tbl_din, 16'h0012);
    check("drain_hbin", tbl_hbin, 1);
    step();
    lk_req = 1'b1; lk_pc = 16'h0012;
    step();
    lk_req = 1'b0;
    step();

    // Starvation limit with a folded index and forwarding.
    up_req = 1'b1; up_pc = 16'h00D0; up_taken = 1'b1;
    lk_req = 1'b1; lk_pc = 16'h00D0;
    step();
    up_req = 1'b0;
    grants = 0;
    found  = 1'b0;
    for (int n = 0; n < 10 && !found; n++) begin
      @(negedge clk);
      if (lk_ready) grants++;
      else begin
        found = 1'b1;
        check("starve_w", tbl_w, 1);
        check("starve_addr", tbl_addr, 8);
        check("starve_din", tbl_din, 16'h00D0);
      end
      step();
    end
    check("starve_found", found, 1);
    check("starve_grants", grants, 4);
    lk_pc = 16'h0108;
    step();
    lk_req = 1'b0;
    step();
    step();

    // Three back-to-back updates to one index with a lookup held.
    pcs[0] = 16'h0130; pcs[1] = 16'h0230; pcs[2] = 16'h0330;
    lk_req = 1'b1; lk_pc = 16'h0330;
    forced = 1'b0;
    for (int j = 0; j < 3; j++) begin
      up_req = 1'b1; up_pc = pcs[j]; up_taken = (j != 1);
      got = 1'b0;
      for (int n = 0; n < 8 && !got; n++) begin
        @(negedge clk);
        if (up_ready) begin
          got = 1'b1;
          if (j == 2) forced = !lk_ready && tbl_w;
        end
        step();
      end
      check("burst_accept", got, 1);
    end
    up_req = 1'b0;
    check("burst_forced_drain", forced, 1);
    step();
    step();
    lk_req = 1'b0;
    repeat (3) step();
    check("burst_tbl_pc", mem_pc[8'h30], 16'h0330);
    check("burst_tbl_hb", mem_hb[8'h30], 1);

    // Invalidate with two queued updates.
    lk_req = 1'b1; lk_pc = 16'h0055;
    up_req = 1'b1; up_pc = 16'h0040; up_taken = 1'b1;
    step();
    up_pc = 16'h0041;
    step();
    up_req = 1'b0; inv = 1'b1;
    step();
    inv = 1'b0; lk_req = 1'b0;
    for (int k = 0; k < SIZE; k++) begin
      @(negedge clk);
      check("inv_busy", busy, 1);
      check("inv_addr", tbl_addr, k);
      step();
    end
    @(negedge clk);
    check("inv_done", busy, 0);
    step();
    lk_req = 1'b1; lk_pc = 16'h0012;
    step();
    lk_pc = 16'h0000;
    step();
    lk_req = 1'b0;
    step();
    step();

    // Randomized traffic, occasionally invalidated.
    for (int c = 0; c < 1500; c++) begin
      lk_req   = ($urandom % 10) < 7;
      lk_pc    = rnd_pc();
      up_req   = ($urandom % 10) < 4;
      up_pc    = rnd_pc();
      up_taken = 1'($urandom);
      inv      = ($urandom % 700) == 0;
      step();
    end
    lk_req = 1'b0; up_req = 1'b0; inv = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 300 && !found; n++) begin
      @(negedge clk);
      if (!busy) found = 1'b1;
      step();
    end
    check("final_run", found, 1);
    repeat (4) step();
    for (int i = 0; i < SIZE; i++) begin
      check("final_tbl_pc", mem_pc[i], mdl_pc[i]);
      check("final_tbl_hb", mem_hb[i], mdl_hb[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hbt_ctrl.md
Name: hbt_ctrl

Overview:
Controller for the single-port history bit table (HBT), the direct-mapped branch history store in the pipelined RISC core. It shares the one table port between the fetch-stage lookup requester and the execute-stage update requester. It buffers resolved-branch updates in a 2-entry queue and forwards buffered updates to lookups. It also sequences a table-wide clear after reset or on an invalidate request, because the parent ties the table's own reset_n inactive.

Parameters:
SIZE, 200, number of HBT entries; must match the table instance.
IDX_W, 8, index bits taken from the PC; 2**IDX_W >= SIZE.
STARVE_MAX, 4, consecutive lookup grants allowed while an update is pending.

Ports:
clk  in  1  clock; table writes on negedge, controller state on posedge.
reset  in  1  asynchronous, active-high.
inv  in  1  pulse: invalidate whole table (restart clear walk).
lk_req  in  1  fetch lookup request.
lk_pc  in  16  fetch PC.
lk_ready  out  1  lookup accepted this cycle when lk_req & lk_ready.
lk_vld  out  1  lookup response valid (one cycle after accept).
lk_hit  out  1  stored PC matched lk_pc.
lk_taken  out  1  predict taken (hit & history bit).
up_req  in  1  resolved-branch update request.
up_pc  in  16  branch PC.
up_taken  in  1  resolved direction.
up_ready  out  1  update accepted when up_req & up_ready (queue not full).
tbl_addr  out  16  table address.
tbl_din  out  16  PC to store.
tbl_w  out  1  table write enable.
tbl_hbin  out  1  history bit to store.
tbl_dout  in  16  table read PC (combinational).
tbl_hbout  in  1  table read history bit.
busy  out  1  clear walk in progress.

Behaviour:
- Index: i = pc[IDX_W-1:0]; if i >= SIZE then i - SIZE. tbl_addr = zero-extended index.
- FSM states: CLEAR, RUN.
- CLEAR is entered on reset and on inv from any state. clr_ptr counts 0..SIZE-1 and drives tbl_addr = clr_ptr, tbl_w = 1, tbl_din = 0, tbl_hbin = 0. Leave to RUN after writing SIZE-1. CLEAR lasts SIZE cycles.
- Reset values: state CLEAR, clr_ptr 0, queue empty, starve 0, lk_vld 0, lk_hit 0, lk_taken 0, busy 1, lk_ready 0, up_ready 0.
- In CLEAR: lk_ready = 0. Update queue contents are discarded on entry. up_ready = 0.
- inv during CLEAR restarts clr_ptr at 0.
- RUN arbitration per cycle:
  - Queue empty: lookup owns the port. lk_ready = 1.
  - Queue non-empty and no lk_req: drain the head. tbl_addr = idx(head.pc), tbl_din = head.pc, tbl_hbin = head.taken, tbl_w = 1. Pop.
  - Queue non-empty and lk_req: lookup wins and starve increments, unless starve == STARVE_MAX or the queue is full. In that case the update drains, lk_ready = 0, and starve is cleared.
  - starve also clears whenever an update drains.
- Lookup accept: tbl_addr = idx(lk_pc), tbl_w = 0. Next cycle: lk_vld = 1, lk_hit = (tbl_dout == lk_pc), lk_taken = lk_hit & tbl_hbout, all registered at the accept posedge.
- Forwarding: if a queue entry has idx equal to idx(lk_pc), the newest such entry overrides the table result. hit = (entry.pc == lk_pc), taken = hit & entry.taken.
- Queue: 2 entries, FIFO. up_ready = (count < 2) | pop-this-cycle, so a simultaneous push and pop when full is allowed.
- A push in the same cycle as a pop of the last entry leaves count = 1.
- A pushed entry is not forwarded until the cycle after the push.
- lk_vld is single-cycle per accept; back-to-back accepts give back-to-back lk_vld.
- Reset mid-walk returns clr_ptr to 0 asynchronously.
- PC 0 after clear reads as hit, not-taken. This is harmless and intentional.

Decomposition:
- Shared package: index-fold function, FSM state encoding (CLEAR, RUN), queue entry struct {pc[15:0], taken}.
- One natural sub-module: hbt_upd_fifo (2-entry FIFO with push/pop/count and per-entry read-out for the forwarding compare).

Test Plan:
- Reset released -> busy = 1 for 200 cycles. tbl_w = 1 with tbl_addr 0..199, din 0. Then busy = 0, lk_ready = 1.
- Update pc = 0x0012, taken = 1, no lookup -> next cycle tbl_w = 1, addr 0x12, din 0x0012, hbin 1. A later lookup of 0x0012 gives lk_vld, lk_hit = 1, lk_taken = 1.
- Update pc = 0x00D0 (index 0xD0 folds to 8) with continuous lookups: forwarded lookup of 0x00D0 gives hit = 1, taken = 1 before the table write. After 4 lookup grants, lk_ready = 0 for one cycle and the table write to addr 8 occurs.
- Lookup pc = 0x0108 (index 8) after the 0x00D0 update -> lk_hit = 0, lk_taken = 0 (alias mismatch).
- Three updates in consecutive cycles with lk_req held -> third sees up_ready = 0 until a forced drain. No update is lost; table order matches issue order.
- inv asserted mid-run with 2 queued updates -> queue flushed, 200-cycle clear. A subsequent lookup of a previously taken PC gives hit = 0 (except PC 0).
